// File: rtl/regfile_wb_if.sv
// Writeback/register-file bus: ALU result and load data in, operand reads and status flags out.
interface regfile_wb_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic [DW-1:0] Y;
    logic [DW-1:0] DIN;
    logic          WSEL;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic          CI;
    logic          FLAG_WE;
    logic [AW-1:0] RADDR_A;
    logic [AW-1:0] RADDR_B;
    logic [DW-1:0] RDATA_A;
    logic [DW-1:0] RDATA_B;
    logic          ZF;
    logic          NF;
    logic          CF;

    modport master (
        output Y, DIN, WSEL, WE, WADDR, CI, FLAG_WE, RADDR_A, RADDR_B,
        input  RDATA_A, RDATA_B, ZF, NF, CF
    );

    modport slave (
        input  Y, DIN, WSEL, WE, WADDR, CI, FLAG_WE, RADDR_A, RADDR_B,
        output RDATA_A, RDATA_B, ZF, NF, CF
    );
endinterface

// File: rtl/regfile_wb.sv
// Writeback stage: selects ALU result or load data, stores it into the register file and
// updates Z/N/C flags; two combinational read ports feed the next instruction's operands.
module regfile_wb #(
    parameter int DW      = 8,
    parameter int NREG    = 8,
    parameter int AW      = 3,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_wb_if.slave  bus
);
    logic [DW-1:0]      wdata;
    logic [NREG*DW-1:0] regs_flat;
    logic               zf_reg;
    logic               nf_reg;
    logic               cf_reg;

    assign wdata = bus.WSEL ? bus.DIN : bus.Y;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (ZERO_R0 && gi == 0) begin : g_zero
                // Hard-wired zero register: writes to it are simply never captured.
                assign regs_flat[gi*DW +: DW] = '0;
            end else begin : g_store
                logic [DW-1:0] q_reg;
                logic          hit;

                assign hit = bus.WE && (bus.WADDR == AW'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (hit) begin
                        q_reg <= wdata;
                    end
                end

                assign regs_flat[gi*DW +: DW] = q_reg;
            end
        end
    endgenerate

    // Flags follow wdata even when the register write is disabled or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zf_reg <= 1'b0;
            nf_reg <= 1'b0;
            cf_reg <= 1'b0;
        end else if (bus.FLAG_WE) begin
            zf_reg <= (wdata == '0);
            nf_reg <= wdata[DW-1];
            cf_reg <= bus.CI;
        end
    end

    // No write-to-read bypass: reads see the pre-edge contents.
    assign bus.RDATA_A = regs_flat[bus.RADDR_A*DW +: DW];
    assign bus.RDATA_B = regs_flat[bus.RADDR_B*DW +: DW];
    assign bus.ZF      = zf_reg;
    assign bus.NF      = nf_reg;
    assign bus.CF      = cf_reg;
endmodule
